bcd_countdown_60: RTL
=====================

// Module: bcd_countdown_60
// PURPOSE
//  Mod-60 BCD down-counter (countdown timer): loads a 00..59 BCD value, then
//  counts down to 00 on a prescaled tick and flags completion. It is the
//  down-counting counterpart of the mod-60 up-counter and uses the same Q
//  format: tens in Q[7:4] (0..5), units in Q[3:0] (0..9). Q feeds the same
//  display and compare logic as the up-counter.
// PARAMETERS
//  TICK_DIV     4  clock cycles per count step (>=1; 1 = step every cycle)
//  AUTO_RELOAD  0  1 = on reaching 00, reload the last loaded value and keep running
// PORTS
//  clk       in   1  clock, rising edge
//  rst       in   1  synchronous reset, active-high
//  load      in   1  load load_val into Q (any state)
//  load_val  in   8  BCD preset, [7:4] tens 0..5, [3:0] units 0..9
//  start     in   1  start from IDLE, or resume from HOLD
//  stop      in   1  pause a RUN (go to HOLD)
//  Q         out  8  current BCD count (registered)
//  running   out  1  1 while state==RUN
//  done      out  1  1-cycle pulse, same cycle Q first shows 00 from a count step
//  err       out  1  1-cycle pulse, load rejected (invalid BCD or value >59)
// BEHAVIOUR
//  Reset: Q=8'h00, state=IDLE, prescaler=0, reload_reg=8'h00, running=0, done=0, err=0.
//  States: IDLE, RUN, HOLD. All outputs registered. Control priority per edge:
//   rst > load > stop > start.
//  load: load_val valid (tens<=5, units<=9) -> Q<=load_val, reload_reg<=load_val,
//   state<=IDLE, prescaler<=0. Invalid -> err=1 for 1 cycle; Q, state and
//   prescaler unchanged.
//  IDLE + start: Q!=00 -> RUN, prescaler<=0. Q==00 -> start ignored, stay IDLE.
//  RUN + stop -> HOLD; prescaler and Q frozen. RUN + start -> no effect.
//  HOLD + start -> RUN; the prescaler resumes from its frozen value (not cleared).
//   HOLD + stop -> no effect.
//  Prescaler (RUN only): counts 0..TICK_DIV-1. A step fires on the edge where
//   it equals TICK_DIV-1, and the prescaler wraps to 0 on that edge.
//  Latency: start sampled at edge k -> running=1 after edge k; first step at
//   edge k+TICK_DIV.
//  Step arithmetic: units!=0 -> units-1. units==0 -> units<=9, tens<=tens-1.
//   Q never leaves the BCD range 00..59.
//  Terminal step (Q 01->00): done=1 for that cycle.
//   AUTO_RELOAD=0: state<=IDLE, running=0, Q stays 00.
//   AUTO_RELOAD=1: stay RUN; on the next step Q<=reload_reg (not 59), then
//    counting continues.
//  AUTO_RELOAD=1 with reload_reg==00: treated as AUTO_RELOAD=0, so the counter
//   never runs from 00.
//  load and stop on the same edge: the load wins -> IDLE. start and stop on the
//   same edge: stop wins.
//  rst in any state, including mid-RUN: full reset values on the next edge;
//   no done pulse.
//  done and err never assert on the same edge. A load on a terminal-step edge
//   cancels the step: no done.
// TESTING
//  T1 reset: rst=1 two cycles with random controls -> Q=00, running=0, done=0, err=0.
//  T2 full count, TICK_DIV=1: load 8'h59, start -> Q steps 58,57..50,49..01,00
//   one per cycle. Exactly 59 steps; done high only with Q=00; running=0 after.
//  T3 pause/resume, TICK_DIV=4: load 8'h10, start, wait 3 steps (Q=07),
//   stop mid-prescale -> Q holds 07 for 20 cycles. start -> Q=06 after the
//   remaining prescale count, not a full 4 cycles.
//  T4 invalid loads: load_val 8'h5A, 8'h60, 8'hFF -> err pulse each, Q unchanged.
//   A load of 8'h00 then start -> stays IDLE, no done.
//  T5 auto reload, AUTO_RELOAD=1, TICK_DIV=1: load 8'h02, start ->
//   Q 01,00(done),02,01,00(done)... running stays 1.
//  T6 mid-run override: while RUN at Q=8'h33, drive load=1 with 8'h30 ->
//   Q=30, IDLE, no done. Restart, then rst=1 at Q=8'h25 -> Q=00, no done.

Source files
------------

// File: rtl/bcd_countdown_60.sv
// Mod-60 BCD countdown timer: loads 00..59, counts down on a prescaled tick.
// Ports: clk, rst (sync high), load/load_val, start, stop -> Q, running, done, err.
module bcd_countdown_60 #(
  parameter int TICK_DIV    = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] Q,
  output logic       running,
  output logic       done,
  output logic       err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t        state;
  logic [PW-1:0] ps;
  logic [7:0]    reload_reg;

  logic       load_ok;
  logic       q_zero;
  logic       tick;
  logic       keep_run;
  logic [7:0] q_dec;

  assign load_ok  = (load_val[7:4] <= 4'd5) && (load_val[3:0] <= 4'd9);
  assign q_zero   = (Q == 8'h00);
  assign tick     = (ps == PS_LAST);
  // A zero reload value would make the counter run from 00; treat as one-shot.
  assign keep_run = AUTO_RELOAD && (reload_reg != 8'h00);

  always_comb begin
    q_dec = Q;
    if (Q[3:0] != 4'd0) begin
      q_dec = {Q[7:4], Q[3:0] - 4'd1};
    end else begin
      q_dec = {Q[7:4] - 4'd1, 4'd9};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ps         <= '0;
      reload_reg <= 8'h00;
      Q          <= 8'h00;
      running    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Any load owns the edge, even a rejected one: no step, no state move.
      if (load) begin
        if (load_ok) begin
          Q          <= load_val;
          reload_reg <= load_val;
          state      <= IDLE;
          ps         <= '0;
          running    <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else if (stop) begin
        if (state == RUN) begin
          state   <= HOLD;
          running <= 1'b0;
        end
      end else begin
        unique case (state)
          RUN: begin
            if (tick) begin
              ps <= '0;
              if (q_zero) begin
                // Only reachable while auto-reloading after a terminal step.
                Q <= reload_reg;
              end else begin
                Q <= q_dec;
                if (Q == 8'h01) begin
                  done <= 1'b1;
                  if (!keep_run) begin
                    state   <= IDLE;
                    running <= 1'b0;
                  end
                end
              end
            end else begin
              ps <= ps + 1'b1;
            end
          end
          IDLE: begin
            if (start && !q_zero) begin
              state   <= RUN;
              ps      <= '0;
              running <= 1'b1;
            end
          end
          HOLD: begin
            // Prescaler keeps its frozen phase across the pause.
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
